fwd_hazard_unit: RTL and testbench

- Control-side counterpart of the ALU operand forwarding muxes. It produces the fa/fb forward-select codes that steer EX-stage operands A and B.
- Tracks destination registers of instructions in EX, MEM and WB with an internal shadow pipeline that advances in lockstep with the IDEX/EXMEM/MEMWB registers.
- Detects load-use hazards and issues a one-cycle stall plus EX bubble.
- Sits beside the ID/EX boundary of the 5-stage MIPS pipeline.

---
 rtl/mips_pkg.sv | 53 +++++
 rtl/fwd_sel.sv | 26 ++
 rtl/fwd_hazard_unit.sv | 136 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, forward-select codes, shadow slot
// type and the instruction decode used by the hazard/forwarding control.
package mips_pkg;

  localparam int RN_W = 5;

  localparam logic [5:0] ALUop   = 6'b000000;
  localparam logic [5:0] LW      = 6'b100011;
  localparam logic [5:0] SW      = 6'b101011;
  localparam logic [5:0] ADD_IMM = 6'b001000;
  localparam logic [5:0] Jop     = 6'b000010;
  localparam logic [5:0] JALop   = 6'b000011;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic            wr;
    logic [RN_W-1:0] dst;
    logic            is_load;
  } slot_t;

  typedef struct packed {
    logic            reads_rs;
    logic            reads_rt;
    logic            wr;
    logic [RN_W-1:0] dst;
    logic            is_load;
  } dec_t;

  function automatic dec_t decode(input logic [5:0]      op,
                                  input logic [RN_W-1:0] rt,
                                  input logic [RN_W-1:0] rd);
    dec_t d;
    d = '0;
    case (op)
      ALUop:   begin d.reads_rs = 1'b1; d.reads_rt = 1'b1; d.wr = 1'b1; d.dst = rd; end
      LW:      begin d.reads_rs = 1'b1; d.wr = 1'b1; d.dst = rt; d.is_load = 1'b1; end
      ADD_IMM: begin d.reads_rs = 1'b1; d.wr = 1'b1; d.dst = rt; end
      SW:      begin d.reads_rs = 1'b1; d.reads_rt = 1'b1; end
      JALop:   begin d.wr = 1'b1; d.dst = 5'd31; end
      default: d = '0;
    endcase
    // r0 is hardwired: a write to it never produces a value worth tracking
    if (d.dst == '0) begin
      d.wr      = 1'b0;
      d.is_load = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Forward-select for one EX operand: youngest in-flight producer of the
// source register wins; WB needs no forward since the register file is write-first.
module fwd_sel
  import mips_pkg::*;
#(
  parameter int AW = RN_W
) (
  input  logic [AW-1:0] src,
  input  logic          used,
  input  slot_t         ex,
  input  slot_t         mem,
  output logic [1:0]    sel
);

  logic unused_ld;
  assign unused_ld = ex.is_load ^ mem.is_load;

  always_comb begin
    sel = FWD_RF;
    if (used) begin
      if (ex.wr && (ex.dst == src))        sel = FWD_MEM;
      else if (mem.wr && (mem.dst == src)) sel = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ID/EX-side forwarding and load-use hazard control for the 5-stage MIPS pipe.
// Define FWD_STATS_EN to add saturating stall/forward statistics counters.
//
// state    | meaning
// RUN      | normal issue
// LU_STALL | one bubble inserted; the producing LW now sits in MEM
module fwd_hazard_unit
  import mips_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        pipe_en,
  input  logic        id_valid,
  input  logic [31:0] id_ir,
  input  logic        flush,
  output logic [1:0]  fa,
  output logic [1:0]  fb,
  output logic        stall,
  output logic        ex_bubble
`ifdef FWD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] fwd_cnt
`endif
);

  typedef enum logic {RUN, LU_STALL} state_t;

  state_t      state_q, state_n;
  slot_t       ex_q, mem_q, wb_q;
  dec_t        dec;
  logic [4:0]  rs, rt;
  logic [1:0]  fa_n, fb_n;
  logic        issue;
  logic        hit_rs, hit_rt;

  assign rs  = id_ir[25:21];
  assign rt  = id_ir[20:16];
  assign dec = decode(id_ir[31:26], rt, id_ir[15:11]);

  logic unused_ir;
  assign unused_ir = ^id_ir[10:0];

  assign hit_rs = dec.reads_rs && (rs == ex_q.dst);
  assign hit_rt = dec.reads_rt && (rt == ex_q.dst);
  assign stall  = id_valid && !flush && ex_q.wr && ex_q.is_load && (hit_rs || hit_rt);
  assign issue  = id_valid && !flush && !stall;

  fwd_sel #(.AW(REG_AW)) u_sel_a (
    .src  (rs),
    .used (dec.reads_rs),
    .ex   (ex_q),
    .mem  (mem_q),
    .sel  (fa_n)
  );

  fwd_sel #(.AW(REG_AW)) u_sel_b (
    .src  (rt),
    .used (dec.reads_rt),
    .ex   (ex_q),
    .mem  (mem_q),
    .sel  (fb_n)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      fa        <= FWD_RF;
      fb        <= FWD_RF;
      ex_bubble <= 1'b1;
    end else if (pipe_en) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (issue) begin
        ex_q      <= '{wr: dec.wr, dst: dec.dst, is_load: dec.is_load};
        fa        <= fa_n;
        fb        <= fb_n;
        ex_bubble <= 1'b0;
      end else begin
        ex_q      <= '0;
        fa        <= FWD_RF;
        fb        <= FWD_RF;
        ex_bubble <= 1'b1;
      end
    end
  end

  logic unused_wb;
  assign unused_wb = ^wb_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= RUN;
    else          state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      RUN:      if (stall && pipe_en) state_n = LU_STALL;
      LU_STALL: if (pipe_en)          state_n = RUN;
      default:  state_n = RUN;
    endcase
  end

`ifdef FWD_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else if (pipe_en) begin
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (issue && ((fa_n != FWD_RF) || (fb_n != FWD_RF)) && !(&fwd_cnt))
        fwd_cnt <= fwd_cnt + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

  // The bubble behind a load guarantees these never fire in a legal pipeline
  always @(posedge clock) begin
    if (reset_n) begin
      assert (!(state_q == LU_STALL && stall));
      assert (!(pipe_en && issue && ex_q.is_load &&
                ((fa_n == FWD_MEM) || (fb_n == FWD_MEM))));
      assert (!(wb_q.is_load && !wb_q.wr) && !(wb_q.wr && (wb_q.dst == '0)));
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios followed by
// random instruction streams compared against a register-history model.
module tb_fwd_hazard_unit;

  logic        clock = 1'b0;
  logic        reset_n, pipe_en, id_valid, flush;
  logic [31:0] id_ir;
  logic [1:0]  fa, fb;
  logic        stall, ex_bubble;
`ifdef FWD_STATS_EN
  logic [15:0] stall_cnt, fwd_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {int dst; bit ld;} ent_t;
  ent_t hist[$];
  int   e_fa, e_fb, e_scnt, e_fcnt;
  bit   e_bub;

  fwd_hazard_unit dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .pipe_en   (pipe_en),
    .id_valid  (id_valid),
    .id_ir     (id_ir),
    .flush     (flush),
    .fa        (fa),
    .fb        (fb),
    .stall     (stall),
    .ex_bubble (ex_bubble)
`ifdef FWD_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .fwd_cnt   (fwd_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference decode: destination 0 means "writes nothing useful"
  function automatic int dest_of(logic [31:0] ir);
    case (ir[31:26])
      6'd0:        return int'(ir[15:11]);
      6'd35, 6'd8: return int'(ir[20:16]);
      6'd3:        return 31;
      default:     return 0;
    endcase
  endfunction

  function automatic bit uses_a(logic [31:0] ir);
    return ir[31:26] inside {6'd0, 6'd35, 6'd8, 6'd43};
  endfunction

  function automatic bit uses_b(logic [31:0] ir);
    return ir[31:26] inside {6'd0, 6'd43};
  endfunction

  function automatic int pick(int src, bit used);
    if (!used || src == 0) return 0;
    if (src == hist[0].dst) return 2;
    if (src == hist[1].dst) return 1;
    return 0;
  endfunction

  function automatic bit hazard(logic [31:0] ir);
    int a, b;
    a = int'(ir[25:21]);
    b = int'(ir[20:16]);
    if (!hist[0].ld) return 0;
    return (uses_a(ir) && a != 0 && a == hist[0].dst) ||
           (uses_b(ir) && b != 0 && b == hist[0].dst);
  endfunction

  task automatic model_reset();
    ent_t z;
    z.dst = 0; z.ld = 0;
    hist.delete();
    hist.push_back(z);
    hist.push_back(z);
    e_fa = 0; e_fb = 0; e_bub = 1; e_scnt = 0; e_fcnt = 0;
  endtask

  task automatic check_outs(string tag);
    chk({tag, "_fa"}, 16'(fa), 16'(e_fa));
    chk({tag, "_fb"}, 16'(fb), 16'(e_fb));
    chk({tag, "_bub"}, 16'(ex_bubble), 16'(e_bub));
`ifdef FWD_STATS_EN
    chk({tag, "_scnt"}, stall_cnt, 16'(e_scnt));
    chk({tag, "_fcnt"}, fwd_cnt, 16'(e_fcnt));
`endif
  endtask

  task automatic step(bit v, logic [31:0] ir, bit fl, bit pe);
    bit   e_st;
    int   na, nb;
    ent_t n;
    @(negedge clock);
    id_valid = v; id_ir = ir; flush = fl; pipe_en = pe;
    #1;
    e_st = v && !fl && hazard(ir);
    chk("stall", 16'(stall), 16'(e_st));
    na = pick(int'(ir[25:21]), uses_a(ir));
    nb = pick(int'(ir[20:16]), uses_b(ir));
    @(posedge clock);
    #1;
    if (pe) begin
      if (v && !fl && !e_st) begin
        n.dst = dest_of(ir);
        n.ld  = (ir[31:26] == 6'd35) && (n.dst != 0);
        e_fa = na; e_fb = nb; e_bub = 0;
        if ((na != 0 || nb != 0) && e_fcnt < 65535) e_fcnt++;
      end else begin
        n.dst = 0; n.ld = 0;
        e_fa = 0; e_fb = 0; e_bub = 1;
      end
      if (e_st && e_scnt < 65535) e_scnt++;
      hist.push_front(n);
      void'(hist.pop_back());
    end
    check_outs("step");
  endtask

  task automatic async_reset();
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outs("rst");
    chk("rst_stall", 16'(stall), 16'd0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] r_ins(int rd, int rs, int rt);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] i_ins(logic [5:0] op, int rt, int rs);
    return {op, 5'(rs), 5'(rt), 16'h0004};
  endfunction

  function automatic int rreg();
    return ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rnd_ins();
    case ($urandom_range(0, 6))
      0:       return r_ins(rreg(), rreg(), rreg());
      1:       return i_ins(6'd35, rreg(), rreg());
      2:       return i_ins(6'd8, rreg(), rreg());
      3:       return i_ins(6'd43, rreg(), rreg());
      4:       return {6'd2, 26'(r_ins(rreg(), rreg(), rreg()))};
      5:       return {6'd3, 26'h0000100};
      default: return {6'h3f, 5'(rreg()), 5'(rreg()), 16'h0};
    endcase
  endfunction

  initial begin
    reset_n = 1'b1; pipe_en = 1'b1; id_valid = 1'b0; flush = 1'b0; id_ir = '0;
    #2 reset_n = 1'b0;
    #2;
    model_reset();
    check_outs("init");
    chk("init_stall", 16'(stall), 16'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // EX-to-EX forward of operand A
    step(1, r_ins(3, 1, 2), 0, 1);
    step(1, r_ins(4, 3, 1), 0, 1);
    chk("t1_fa", 16'(fa), 16'd2);
    chk("t1_fb", 16'(fb), 16'd0);

    // MEM forward of store data across a gap
    step(1, r_ins(3, 1, 2), 0, 1);
    step(0, 32'h0, 0, 1);
    step(1, i_ins(6'd43, 3, 5), 0, 1);
    chk("t2_fa", 16'(fa), 16'd0);
    chk("t2_fb", 16'(fb), 16'd1);

    // load-use stall then WB-path forward
    step(1, i_ins(6'd35, 2, 1), 0, 1);
    step(1, r_ins(4, 2, 2), 0, 1);
    chk("t3_bub", 16'(ex_bubble), 16'd1);
    step(1, r_ins(4, 2, 2), 0, 1);
    chk("t3_fa", 16'(fa), 16'd1);
    chk("t3_fb", 16'(fb), 16'd1);

    // r0 never forwarded; JAL link register is
    step(1, r_ins(0, 1, 1), 0, 1);
    step(1, r_ins(5, 0, 0), 0, 1);
    chk("t4_r0", 16'({fa, fb}), 16'd0);
    step(1, {6'd3, 26'h0000040}, 0, 1);
    step(1, r_ins(6, 31, 0), 0, 1);
    chk("t4_jal", 16'(fa), 16'd2);

    // flush beats a load-use hazard
    step(1, i_ins(6'd35, 2, 1), 0, 1);
    step(1, r_ins(4, 2, 2), 1, 1);
    chk("t5_bub", 16'(ex_bubble), 16'd1);

    // freeze with a pending hazard: stall visible, nothing advances
    step(1, r_ins(7, 1, 1), 0, 1);
    step(1, i_ins(6'd35, 2, 7), 0, 1);
    for (int i = 0; i < 3; i++) step(1, r_ins(4, 2, 2), 0, 0);
    chk("t5_frz", 16'(fa), 16'd2);
    step(1, r_ins(4, 2, 2), 0, 1);
    step(1, r_ins(4, 2, 2), 0, 1);

    // reset while in LU_STALL
    step(1, i_ins(6'd35, 2, 1), 0, 1);
    step(1, r_ins(4, 2, 2), 0, 1);
    async_reset();
    step(1, r_ins(4, 2, 2), 0, 1);
    chk("t6_nostall_fa", 16'(fa), 16'd0);

    for (int i = 0; i < 400; i++) begin
      if (i % 130 == 129) async_reset();
      step($urandom_range(0, 9) != 0, rnd_ins(),
           $urandom_range(0, 9) == 0, $urandom_range(0, 6) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
